// File: rtl/ecc_rd_resp_stage_pkg.sv
// ecc_rd_resp_stage_pkg: shared ECC codeword geometry and field helpers
package ecc_rd_resp_stage_pkg;
  localparam int ECC_DATA_W = 32;
  localparam int ECC_CHK_W = 7;
  localparam int ECC_CW_W = ECC_DATA_W + ECC_CHK_W;
  function automatic logic [ECC_DATA_W-1:0] cw_data(input logic [ECC_CW_W-1:0] w);
    return w[ECC_DATA_W-1:0];
  endfunction
endpackage

// File: rtl/ecc_scrub_fifo.sv
// ecc_scrub_fifo: registered-storage FIFO of {addr, codeword} scrub write-backs
module ecc_scrub_fifo
  import ecc_rd_resp_stage_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [ADDR_W-1:0]   din_addr,
  input  logic [ECC_CW_W-1:0] din_word,
  input  logic                pop,
  output logic                full,
  output logic                empty,
  output logic [ADDR_W-1:0]   dout_addr,
  output logic [ECC_CW_W-1:0] dout_word
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = ADDR_W + ECC_CW_W;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign {dout_addr, dout_word} = mem_q[rd_q];
  // next-state: pointers wrap naturally since DEPTH is a power of 2
  always_comb begin
    do_pop = pop & ~empty;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {din_addr, din_word};
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(do_pop);
  end
  // state registers; reset empties the queue and zeroes the head outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ecc_rd_resp_stage.sv
// ecc_rd_resp_stage: registered read response, scrub queueing and ECC error bookkeeping
module ecc_rd_resp_stage
  import ecc_rd_resp_stage_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int SCRUB_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [ECC_CW_W-1:0]   in_word,
  input  logic                  in_sgl,
  input  logic                  in_dbl,
  input  logic                  scrub_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ECC_DATA_W-1:0] out_data,
  output logic                  out_sgl,
  output logic                  out_dbl,
  output logic                  scrub_valid,
  input  logic                  scrub_ready,
  output logic [ADDR_W-1:0]     scrub_addr,
  output logic [ECC_CW_W-1:0]   scrub_word,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      sgl_cnt,
  output logic [CNT_W-1:0]      dbl_cnt,
  output logic                  dbl_seen,
  output logic [ADDR_W-1:0]     dbl_addr
);
  logic out_valid_q, out_valid_d, out_sgl_q, out_sgl_d, out_dbl_q, out_dbl_d;
  logic dbl_seen_q, dbl_seen_d;
  logic [ECC_DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] sgl_cnt_q, sgl_cnt_d, dbl_cnt_q, dbl_cnt_d;
  logic [ADDR_W-1:0] dbl_addr_q, dbl_addr_d;
  logic acc, sgl_inc, dbl_inc, push, full, empty;
  ecc_scrub_fifo #(.ADDR_W(ADDR_W), .DEPTH(SCRUB_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din_addr(in_addr), .din_word(in_word),
    .pop(scrub_ready), .full(full), .empty(empty),
    .dout_addr(scrub_addr), .dout_word(scrub_word)
  );
  assign in_ready = (~out_valid_q | out_ready) & ~full;
  assign scrub_valid = ~empty;
  assign {out_valid, out_data, out_sgl, out_dbl} = {out_valid_q, out_data_q, out_sgl_q, out_dbl_q};
  assign {sgl_cnt, dbl_cnt, dbl_seen, dbl_addr} = {sgl_cnt_q, dbl_cnt_q, dbl_seen_q, dbl_addr_q};
  // accept, response load/hold, saturating counters, first-DBL capture; a conflicting SGL+DBL counts as DBL
  always_comb begin
    acc = in_valid & in_ready;
    sgl_inc = acc & in_sgl & ~in_dbl;
    dbl_inc = acc & in_dbl;
    push = sgl_inc & scrub_en;
    out_valid_d = acc | (out_valid_q & ~out_ready);
    out_data_d = acc ? cw_data(in_word) : out_data_q;
    out_sgl_d = acc ? in_sgl & ~in_dbl : out_sgl_q;
    out_dbl_d = acc ? in_dbl : out_dbl_q;
    sgl_cnt_d = cnt_clr ? '0 : (sgl_inc & ~&sgl_cnt_q) ? sgl_cnt_q + CNT_W'(1) : sgl_cnt_q;
    dbl_cnt_d = cnt_clr ? '0 : (dbl_inc & ~&dbl_cnt_q) ? dbl_cnt_q + CNT_W'(1) : dbl_cnt_q;
    dbl_seen_d = ~cnt_clr & (dbl_seen_q | dbl_inc);
    dbl_addr_d = cnt_clr ? '0 : (dbl_inc & ~dbl_seen_q) ? in_addr : dbl_addr_q;
  end
  // response and bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sgl_q <= 1'b0;
      out_dbl_q <= 1'b0;
      sgl_cnt_q <= '0;
      dbl_cnt_q <= '0;
      dbl_seen_q <= 1'b0;
      dbl_addr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sgl_q <= out_sgl_d;
      out_dbl_q <= out_dbl_d;
      sgl_cnt_q <= sgl_cnt_d;
      dbl_cnt_q <= dbl_cnt_d;
      dbl_seen_q <= dbl_seen_d;
      dbl_addr_q <= dbl_addr_d;
    end
  end
endmodule

// File: tb/tb_ecc_rd_resp_stage.sv
// tb_ecc_rd_resp_stage: directed + random check of ecc_rd_resp_stage against a queue-based model
module tb_ecc_rd_resp_stage;
  localparam int CMAX = 15;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready, in_sgl = 0, in_dbl = 0, scrub_en = 0;
  logic [15:0] in_addr = 0;
  logic [38:0] in_word = 0;
  logic out_valid, out_ready = 0, out_sgl, out_dbl;
  logic [31:0] out_data;
  logic scrub_valid, scrub_ready = 0;
  logic [15:0] scrub_addr, dbl_addr;
  logic [38:0] scrub_word;
  logic cnt_clr = 0, dbl_seen;
  logic [3:0] sgl_cnt, dbl_cnt;
  int tests = 0, fails = 0;
  bit m_ov, m_sgl, m_dbl, m_seen;
  logic [31:0] m_data;
  int m_scnt, m_dcnt;
  logic [15:0] m_daddr;
  logic [54:0] m_q [$];
  ecc_rd_resp_stage #(.ADDR_W(16), .SCRUB_DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_word(in_word), .in_sgl(in_sgl), .in_dbl(in_dbl), .scrub_en(scrub_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sgl(out_sgl),
    .out_dbl(out_dbl), .scrub_valid(scrub_valid), .scrub_ready(scrub_ready),
    .scrub_addr(scrub_addr), .scrub_word(scrub_word), .cnt_clr(cnt_clr), .sgl_cnt(sgl_cnt),
    .dbl_cnt(dbl_cnt), .dbl_seen(dbl_seen), .dbl_addr(dbl_addr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit exp_ready();
    return (!m_ov || out_ready) && m_q.size() < 4;
  endfunction
  task automatic check_all();
    chk("in_ready", in_ready, exp_ready());
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_data", out_data, m_data);
      chk("out_sgl", out_sgl, m_sgl);
      chk("out_dbl", out_dbl, m_dbl);
    end
    chk("scrub_valid", scrub_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("scrub_head", {scrub_addr, scrub_word}, m_q[0]);
    chk("sgl_cnt", sgl_cnt, m_scnt);
    chk("dbl_cnt", dbl_cnt, m_dcnt);
    chk("dbl_seen", dbl_seen, m_seen);
    chk("dbl_addr", dbl_addr, m_daddr);
  endtask
  task automatic model_clk();
    bit acc, sg;
    if (rst) begin
      m_ov = 0; m_sgl = 0; m_dbl = 0; m_data = 0; m_scnt = 0; m_dcnt = 0; m_seen = 0; m_daddr = 0;
      m_q.delete();
      return;
    end
    acc = in_valid && exp_ready();
    sg = in_sgl && !in_dbl;
    if (m_q.size() > 0 && scrub_ready) void'(m_q.pop_front());
    if (acc && sg && scrub_en) m_q.push_back({in_addr, in_word});
    if (acc) begin
      m_ov = 1; m_data = in_word[31:0]; m_sgl = sg; m_dbl = in_dbl;
    end else if (out_ready) m_ov = 0;
    if (cnt_clr) begin
      m_scnt = 0; m_dcnt = 0; m_seen = 0; m_daddr = 0;
    end else if (acc) begin
      if (sg && m_scnt < CMAX) m_scnt++;
      if (in_dbl && m_dcnt < CMAX) m_dcnt++;
      if (in_dbl && !m_seen) begin
        m_seen = 1; m_daddr = in_addr;
      end
    end
  endtask
  task automatic step(input bit v, input logic [15:0] a, input logic [38:0] w, input bit s, input bit d,
                      input bit se, input bit ordy, input bit srdy, input bit clr, input bit r);
    @(negedge clk);
    in_valid = v; in_addr = a; in_word = w; in_sgl = s; in_dbl = d; scrub_en = se;
    out_ready = ordy; scrub_ready = srdy; cnt_clr = clr; rst = r;
    #1;
    if (!r) check_all();
    @(posedge clk);
    model_clk();
  endtask
  function automatic logic [38:0] rw();
    return {7'($urandom), 32'($urandom)};
  endfunction
  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_scrub_valid", scrub_valid, 0);
    chk("rst_cnts", {sgl_cnt, dbl_cnt, dbl_seen, dbl_addr}, 0);
    for (int i = 0; i < 8; i++) step(1, 16'(i), rw(), 0, 0, 1, 1, 0, 0, 0);
    step(1, 16'h0012, 39'h55_DEADBEEF, 1, 0, 1, 1, 0, 0, 0);
    #1;
    chk("t2_out_data", out_data, 32'hDEADBEEF);
    chk("t2_out_sgl", out_sgl, 1);
    chk("t2_scrub", {scrub_valid, scrub_addr, scrub_word}, {1'b1, 16'h0012, 39'h55_DEADBEEF});
    chk("t2_sgl_cnt", sgl_cnt, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 16'(i), rw(), 1, 0, 1, 1, 0, 0, 0);
    #1;
    chk("t3_full_rdy", in_ready, 0);
    step(1, 16'd4, 39'h4_0000_0004, 1, 0, 1, 1, 0, 0, 0);
    step(1, 16'd4, 39'h4_0000_0004, 1, 0, 1, 1, 1, 0, 0);
    step(1, 16'd4, 39'h4_0000_0004, 1, 0, 1, 1, 0, 0, 0);
    #1;
    chk("t3_fifo_head", scrub_addr, 16'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    step(1, 16'h0100, rw(), 0, 1, 1, 1, 0, 0, 0);
    step(1, 16'h0200, rw(), 1, 1, 1, 1, 0, 0, 0);
    #1;
    chk("t4_dbl", {dbl_seen, dbl_addr, scrub_valid}, {1'b1, 16'h0100, 1'b0});
    step(1, 16'h0300, rw(), 0, 1, 1, 1, 0, 1, 0);
    #1;
    chk("t4_clr", {dbl_cnt, dbl_seen}, 0);
    step(1, 16'h0400, 39'h0_1234_5678, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 16'h0401, rw(), 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("t5_hold", {out_data, in_ready}, {32'h1234_5678, 1'b0});
    step(1, 16'h0402, 39'h0_CAFE_F00D, 0, 0, 1, 1, 0, 0, 0);
    #1;
    chk("t5_b2b", {out_valid, out_data}, {1'b1, 32'hCAFE_F00D});
    for (int i = 0; i < 17; i++) step(1, 16'(i), rw(), 1, 0, 0, 1, 0, 0, 0);
    #1;
    chk("t6_sat", sgl_cnt, 15);
    for (int i = 0; i < 2; i++) step(1, 16'(i), rw(), 1, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    #1;
    chk("t6_rst_scrub", {scrub_valid, out_valid}, 0);
    for (int i = 0; i < 3000; i++) begin
      int d = $urandom_range(0, 9);
      step($urandom_range(0, 3) != 0, 16'($urandom), rw(), d < 6, d >= 8, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 250) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
